dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipeline's `dmem_*` load/store interface: the memory side of the requests the pipeline initiates. It accepts one read and/or one write request, holds them for a configurable number of wait cycles, then applies byte-enabled writes and returns load data, each qualified by a one-cycle valid pulse. It replaces the always-valid, zero-wait data memory, so the pipeline's stall-on-memory path gets real exercise.

## Interface
Parameters:
- `SIZE`, 4096: storage in bytes. Must be a power of two, at least 8.
- `LATENCY`, 2: cycles from request acceptance to the valid pulse. Must be at least 1.
- `FILE`, "": hex preload for `$readmemh`. An empty string means no preload.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `read_ready`  in  1  load request.
- `read_address`  in  30  word address (byte address bits 31:2).
- `read_data`  out  32  load data. Valid only while `read_valid` is high.
- `read_valid`  out  1  one-cycle load completion.
- `write_ready`  in  1  store request.
- `write_address`  in  30  word address.
- `write_data`  in  32  store data.
- `write_byte`  in  4  byte enables. Bit n enables `write_data[8n+7:8n]`.
- `write_valid`  out  1  one-cycle store completion.
- `busy`  out  1  high in BUSY and RESP.
- `error`  out  1  sticky out-of-range flag. Only present with `DMEM_RANGE_CHECK_EN`; otherwise tied to 0.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If `read_ready` or `write_ready` is high at a clock edge, latch the request flags, both addresses, `write_data` and `write_byte`.
  - Load the wait counter with LATENCY-1.
  - Go to BUSY, or directly to RESP when LATENCY=1.
- **BUSY:**
  - Decrement the counter.
  - When the counter is 0, go to RESP.
  - `read_ready`, `write_ready` and address changes are ignored.
- **RESP:**
  - Assert `read_valid` and/or `write_valid` for the latched kinds.
  - Memory is read before the write is committed (read-before-write).
  - Commit the write at the end of the RESP cycle.
  - Return to IDLE.
- Read and write latched in the same cycle are one transaction. Both valids pulse in the same cycle. A read of the same word returns the old contents.
- `write_byte`=0 is a legal write: it completes with `write_valid` and changes no memory.
- Index is word address bits [log2(SIZE)-3:0]. Upper bits are handled as described under Configuration.
- `read_data` holds its last value outside RESP.

## Timing
- Reset values: `read_valid`=0, `write_valid`=0, `read_data`=0, `busy`=0, `error`=0, state IDLE, counter 0.
- Reset does not clear the storage array.
- Request sampled at edge t, so valid is high in the cycle after edge t+LATENCY-1 and is seen at edge t+LATENCY.
- Back-to-back throughput is one transaction per LATENCY+1 cycles.
- The requester must drop `ready` in the cycle following the valid pulse. A `ready` still high in IDLE is a new request.
- Reset asserted mid-BUSY or mid-RESP:
  - Pending request is discarded.
  - No valid pulse is issued.
  - No partial write is committed.

## Configuration
- `DMEM_RANGE_CHECK_EN` defined:
  - A word address with any bit above the index set is out of range.
  - It sets `error` (sticky until reset).
  - The write is suppressed.
  - `read_data` returns 0.
  - Valid pulses still occur.
- Not defined: upper bits are ignored, the address wraps modulo SIZE, and `error` is constant 0.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE, BUSY, RESP)
  - `DMEM_WORD_BYTES`=4
  - counter width function (`$clog2(LATENCY)`, minimum 1)
- Sub-module `dmem_array`:
  - SIZE/4 x 32 storage
  - asynchronous read port
  - synchronous byte-enabled write port
  - optional `$readmemh(FILE)`
- The FSM, latches and range check live in `dmem_responder`.

## Test plan
All scenarios use LATENCY=2 and SIZE=4096.
- Write 0xDEADBEEF at byte 0x100 with `write_byte`=4'hF, accepted at edge t -> `write_valid` seen only at edge t+2, `busy` high for 2 cycles. A following read of 0x100 -> `read_valid` after 2 cycles, `read_data`=0xDEADBEEF.
- Partial store: write 0x000000AA with `write_byte`=4'b0001 at 0x100 -> read returns 0xDEADBEAA. `write_byte`=0 -> `write_valid` pulses and the word is unchanged.
- Simultaneous read and write of 0x100 with data 0x12345678 -> both valids in the same cycle, `read_data`=0xDEADBEAA. A subsequent read returns 0x12345678.
- `read_ready` toggled and address changed during BUSY -> ignored; the latched address's data is returned; exactly one `read_valid`.
- Reset pulsed one cycle after accepting a write of 0xCAFEF00D to 0x200 (old value 0) -> no `write_valid`, all outputs 0, and a later read of 0x200 returns 0.
- Read of byte 0x2000:
  - With `DMEM_RANGE_CHECK_EN`: `read_data`=0 and `error`=1 stays high until reset.
  - Without the macro: returns the contents of 0x0000.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_WORD_BYTES = 4;

    // Width of the wait counter: enough to hold LATENCY-1, never less than 1 bit
    function automatic int dmem_cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : SIZE/4 x 32-bit word storage with an asynchronous read port
//                and a synchronous byte-enabled write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int    SIZE = 4096,
    parameter string FILE = ""
) (
    input  logic                     clk,
    input  logic [$clog2(SIZE)-3:0]  rd_index,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(SIZE)-3:0]  wr_index,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wr_byte
);

    localparam int c_DEPTH = SIZE / DMEM_WORD_BYTES;

    logic [31:0] mem [c_DEPTH];

    // Combinational read so the responder can capture data on RESP entry
    assign rd_data = mem[rd_index];

    // Byte-lane write; lanes with a clear enable keep their old contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
                if (wr_byte[b]) begin
                    mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory side of the pipeline dmem_* load/store interface.
//                Accepts one read and/or write request, waits LATENCY cycles,
//                then pulses read_valid / write_valid for one cycle. Loads
//                observe memory before the same-transaction store commits.
//                Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range
//                addresses set a sticky error, suppress writes, read as 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    SIZE    = 4096,
    parameter int    LATENCY = 2,
    parameter string FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_ready,
    input  logic [29:0] read_address,
    output logic [31:0] read_data,
    output logic        read_valid,
    input  logic        write_ready,
    input  logic [29:0] write_address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_byte,
    output logic        write_valid,
    output logic        busy,
    output logic        error
);

    localparam int c_IDX_W = $clog2(SIZE) - 2;
    localparam int c_CNT_W = dmem_cnt_width(LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    dmem_state_e         state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                rd_req_q, rd_req_d;
    logic                wr_req_q, wr_req_d;
    logic [29:0]         rd_addr_q, rd_addr_d;
    logic [29:0]         wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic [3:0]          wr_byte_q, wr_byte_d;
    logic                read_valid_q, read_valid_d;
    logic                write_valid_q, write_valid_d;
    logic [31:0]         read_data_q, read_data_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;

    logic [29:0]         w_rd_addr;
    logic [29:0]         w_wr_addr;
    logic                w_rd_oor;
    logic                w_wr_oor;
    logic [31:0]         w_mem_rdata;
    logic                w_mem_we;

    // In IDLE the request is taken straight from the ports so that LATENCY=1
    // can capture load data on the accepting edge; afterwards the latches rule.
    assign w_rd_addr = (state_q == IDLE) ? read_address  : rd_addr_q;
    assign w_wr_addr = (state_q == IDLE) ? write_address : wr_addr_q;

`ifdef DMEM_RANGE_CHECK_EN
    // Any word-address bit above the array index marks the access as invalid
    assign w_rd_oor = |w_rd_addr[29:c_IDX_W];
    assign w_wr_oor = |w_wr_addr[29:c_IDX_W];
`else
    // Upper address bits are dropped: accesses wrap modulo SIZE
    logic w_unused_upper;
    assign w_rd_oor       = 1'b0;
    assign w_wr_oor       = 1'b0;
    assign w_unused_upper = ^{w_rd_addr[29:c_IDX_W], w_wr_addr[29:c_IDX_W]};
`endif

    // Store commits at the end of RESP; reset held low blocks a partial commit
    assign w_mem_we = (state_q == RESP) && wr_req_q && !w_wr_oor && reset;

    dmem_array #(
        .SIZE (SIZE),
        .FILE (FILE)
    ) u_array (
        .clk      (clk),
        .rd_index (w_rd_addr[c_IDX_W-1:0]),
        .rd_data  (w_mem_rdata),
        .wr_en    (w_mem_we),
        .wr_index (wr_addr_q[c_IDX_W-1:0]),
        .wr_data  (wr_data_q),
        .wr_byte  (wr_byte_q)
    );

    // Next-state, request latching and registered response generation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_req_d      = rd_req_q;
        wr_req_d      = wr_req_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_byte_d     = wr_byte_q;
        read_data_d   = read_data_q;
        error_d       = error_q;
        read_valid_d  = 1'b0;
        write_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_ready || write_ready) begin
                    rd_req_d  = read_ready;
                    wr_req_d  = write_ready;
                    rd_addr_d = read_address;
                    wr_addr_d = write_address;
                    wr_data_d = write_data;
                    wr_byte_d = write_byte;
                    cnt_d     = c_CNT_LOAD;
                    state_d   = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - c_CNT_ONE;
                if (cnt_q == c_CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response outputs are registered on the edge that enters RESP, before
        // the store commits, which gives read-before-write ordering.
        if ((state_d == RESP) && (state_q != RESP)) begin
            read_valid_d  = rd_req_d;
            write_valid_d = wr_req_d;
            if (rd_req_d) begin
                read_data_d = w_rd_oor ? 32'h0 : w_mem_rdata;
            end
            if ((rd_req_d && w_rd_oor) || (wr_req_d && w_wr_oor)) begin
                error_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_byte_q     <= '0;
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            read_data_q   <= '0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_byte_q     <= wr_byte_d;
            read_valid_q  <= read_valid_d;
            write_valid_q <= write_valid_d;
            read_data_q   <= read_data_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
        end
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign write_valid = write_valid_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder (SIZE=4096, LATENCY=2).
//                Stimulus pushes expected responses; a negedge monitor pops
//                and compares them whenever a valid pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int SIZE    = 4096;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_ready = 1'b0;
    logic [29:0] read_address = '0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        write_ready = 1'b0;
    logic [29:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_byte = '0;
    logic        write_valid;
    logic        busy;
    logic        error;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    dmem_responder #(
        .SIZE    (SIZE),
        .LATENCY (LATENCY),
        .FILE    ("")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_ready    (read_ready),
        .read_address  (read_address),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .write_ready   (write_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_byte    (write_byte),
        .write_valid   (write_valid),
        .busy          (busy),
        .error         (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per valid pulse and compare it
    always @(negedge clk) begin
        if (reset && (read_valid || write_valid)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got rv=%0b wv=%0b expected none (cycle %0d)",
                         read_valid, write_valid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_valid",  {31'b0, read_valid},  {31'b0, e.rd});
                check("write_valid", {31'b0, write_valid}, {31'b0, e.wr});
                check("resp_cycle",  cyc, e.cyc);
                if (e.rd) check("read_data", read_data, e.data);
            end
        end
    end

    // One transaction: drive, push expectation, drop ready, check busy profile
    task automatic txn(input bit rd, input bit wr, input logic [29:0] ra,
                       input logic [29:0] wa, input logic [31:0] wd,
                       input logic [3:0] wb, input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        read_ready    = rd;
        write_ready   = wr;
        read_address  = ra;
        write_address = wa;
        write_data    = wd;
        write_byte    = wb;
        e.rd   = rd;
        e.wr   = wr;
        e.data = exp_rd;
        e.cyc  = cyc + LATENCY;
        sb.push_back(e);
        @(negedge clk);
        read_ready  = 1'b0;
        write_ready = 1'b0;
        check("busy_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < LATENCY; i++) begin
            @(negedge clk);
            check("busy_tail", {31'b0, busy}, (i < LATENCY - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] exp_oor_data;
        logic [31:0] exp_err;
`ifdef DMEM_RANGE_CHECK_EN
        exp_oor_data = 32'h0;
        exp_err      = 32'd1;
`else
        exp_oor_data = 32'h0BADF00D;
        exp_err      = 32'd0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_read_valid",  {31'b0, read_valid},  32'd0);
        check("rst_write_valid", {31'b0, write_valid}, 32'd0);
        check("rst_read_data",   read_data,            32'h0);
        check("rst_busy",        {31'b0, busy},        32'd0);
        check("rst_error",       {31'b0, error},       32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Known contents at byte 0x200 and byte 0x0
        txn(0, 1, 30'h0, 30'h80, 32'h0000_0000, 4'hF, 32'h0);
        txn(0, 1, 30'h0, 30'h00, 32'h0BAD_F00D, 4'hF, 32'h0);

        // Full write then read of byte 0x100
        txn(0, 1, 30'h0,  30'h40, 32'hDEAD_BEEF, 4'hF, 32'h0);
        txn(1, 0, 30'h40, 30'h0,  32'h0,         4'h0, 32'hDEAD_BEEF);

        // Partial store, then zero-enable store
        txn(0, 1, 30'h0,  30'h40, 32'h0000_00AA, 4'b0001, 32'h0);
        txn(1, 0, 30'h40, 30'h0,  32'h0,         4'h0,    32'hDEAD_BEAA);
        txn(0, 1, 30'h0,  30'h40, 32'hFFFF_FFFF, 4'b0000, 32'h0);
        txn(1, 0, 30'h40, 30'h0,  32'h0,         4'h0,    32'hDEAD_BEAA);

        // Simultaneous read and write: read sees old contents
        txn(1, 1, 30'h40, 30'h40, 32'h1234_5678, 4'hF, 32'hDEAD_BEAA);
        txn(1, 0, 30'h40, 30'h0,  32'h0,         4'h0, 32'h1234_5678);

        // Request inputs wiggled during BUSY/RESP are ignored
        @(negedge clk);
        read_ready   = 1'b1;
        read_address = 30'h40;
        e.rd = 1; e.wr = 0; e.data = 32'h1234_5678; e.cyc = cyc + LATENCY;
        sb.push_back(e);
        @(negedge clk);
        read_ready   = 1'b0;
        read_address = 30'h80;
        @(negedge clk);
        read_ready   = 1'b1;
        read_address = 30'h00;
        @(negedge clk);
        read_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during BUSY discards a pending write
        @(negedge clk);
        write_ready   = 1'b1;
        write_address = 30'h80;
        write_data    = 32'hCAFE_F00D;
        write_byte    = 4'hF;
        @(negedge clk);
        write_ready = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        check("mid_rst_read_valid",  {31'b0, read_valid},  32'd0);
        check("mid_rst_write_valid", {31'b0, write_valid}, 32'd0);
        check("mid_rst_read_data",   read_data,            32'h0);
        check("mid_rst_busy",        {31'b0, busy},        32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        txn(1, 0, 30'h80, 30'h0, 32'h0, 4'h0, 32'h0);

        // Out-of-range read at byte 0x2000
        txn(1, 0, 30'h800, 30'h0, 32'h0, 4'h0, exp_oor_data);
        check("oor_error", {31'b0, error}, exp_err);
        txn(1, 0, 30'h40, 30'h0, 32'h0, 4'h0, 32'h1234_5678);
        check("error_sticky", {31'b0, error}, exp_err);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("error_cleared", {31'b0, error}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Any expectation still queued means a valid pulse never came
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_valid: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
